rate_tick_scheduler: RTL

- Turns the selected sample rate (ms count, 1..200, from the rate-select decoder) into a periodic sample strobe, timed from the 4 MHz base clock.
- Sequences the downstream sampler with a req/ack handshake.
- Applies rate changes only at period boundaries, so no period is ever truncated.
- Detects and counts overruns, i.e. a new sample falling due while the previous request is still pending.

---
 rtl/rate_tick_scheduler.sv | 115 +++++++++++
 1 files changed

// File: rtl/rate_tick_scheduler.sv
// rate_tick_scheduler: turns a millisecond period selection into a periodic
// sample strobe, sequences the sampler through a req/ack handshake, applies
// rate changes only at period boundaries and keeps a saturating overrun count.
module rate_tick_scheduler #(
  parameter int CLK_PER_MS = 4000,
  parameter int OVR_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [23:0]      rate_ms,
  input  logic             sample_ack,
  input  logic             clear_ovr,
  output logic             period_tick,
  output logic             sample_req,
  output logic [23:0]      active_rate,
  output logic             rate_upd,
  output logic             overrun_flag,
  output logic [OVR_W-1:0] overrun_cnt,
  output logic             busy
);

  localparam int MS_W = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
  localparam logic [MS_W-1:0] MS_LAST = MS_W'(CLK_PER_MS - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state;
  logic [MS_W-1:0] ms_cnt;
  logic [23:0]     per_cnt;
  logic [23:0]     eff_rate;
  logic            ms_end;
  logic            terminal;
  logic            overrun;

  // Saturating increment for the overrun counter: holds at all-ones.
  function automatic logic [OVR_W-1:0] sat_inc(input logic [OVR_W-1:0] v);
    return (&v) ? v : v + OVR_W'(1);
  endfunction

  // A zero request is treated as the shortest legal period of 1 ms.
  assign eff_rate = (rate_ms == 24'd0) ? 24'd1 : rate_ms;
  assign ms_end   = (ms_cnt == MS_LAST);
  // Dropping enable on the boundary edge suppresses the tick entirely.
  assign terminal = (state == RUN) && enable && ms_end &&
                    (per_cnt == active_rate - 24'd1);
  assign overrun  = terminal && sample_req && !sample_ack;

  // Control FSM, period counters, handshake and overrun bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      ms_cnt       <= '0;
      per_cnt      <= '0;
      active_rate  <= 24'd1;
      period_tick  <= 1'b0;
      sample_req   <= 1'b0;
      rate_upd     <= 1'b0;
      overrun_flag <= 1'b0;
      overrun_cnt  <= '0;
      busy         <= 1'b0;
    end else begin
      period_tick <= 1'b0;
      rate_upd    <= 1'b0;

      // A clear landing on an overrun edge still records that overrun.
      if (overrun) begin
        overrun_flag <= 1'b1;
        overrun_cnt  <= clear_ovr ? OVR_W'(1) : sat_inc(overrun_cnt);
      end else if (clear_ovr) begin
        overrun_flag <= 1'b0;
        overrun_cnt  <= '0;
      end

      case (state)
        IDLE: begin
          ms_cnt     <= '0;
          per_cnt    <= '0;
          sample_req <= 1'b0;
          if (enable) begin
            state       <= RUN;
            busy        <= 1'b1;
            active_rate <= eff_rate;
            rate_upd    <= (eff_rate != active_rate);
          end
        end
        RUN: begin
          if (!enable) begin
            state      <= IDLE;
            busy       <= 1'b0;
            ms_cnt     <= '0;
            per_cnt    <= '0;
            sample_req <= 1'b0;
          end else begin
            ms_cnt <= ms_end ? '0 : ms_cnt + MS_W'(1);
            if (ms_end)
              per_cnt <= terminal ? 24'd0 : per_cnt + 24'd1;
            // New period starts on the boundary edge itself; the rate
            // sampled here governs the whole of the next period.
            if (terminal) begin
              period_tick <= 1'b1;
              sample_req  <= 1'b1;
              active_rate <= eff_rate;
              rate_upd    <= (eff_rate != active_rate);
            end else if (sample_ack) begin
              sample_req <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
